// File: rtl/repeated_add_multiplier_if.sv
// rtl/repeated_add_multiplier_if.sv - start/busy/done handshake bundle for repeated_add_multiplier
interface repeated_add_multiplier_if #(parameter int WIDTH = 8);
  logic               start;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, a_in, b_in, input busy, done, product);
  modport slave  (input start, a_in, b_in, output busy, done, product);
endinterface

// File: rtl/repeated_add_multiplier.sv
// rtl/repeated_add_multiplier.sv - multiplier that adds A to an accumulator B times
// Define MULT_SIGNED_EN for two's-complement operands (magnitudes iterated, sign applied at the end).
module repeated_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  repeated_add_multiplier_if.slave  bus
);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_a;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_product;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [PW-1:0]    w_result;
  logic             w_eqz;

`ifdef MULT_SIGNED_EN
  logic r_neg;

  // The most negative operand's magnitude still fits as an unsigned WIDTH-bit value.
  assign w_a_mag  = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
  assign w_b_mag  = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
  assign w_result = r_neg ? -r_acc : r_acc;
`else
  assign w_a_mag  = bus.a_in;
  assign w_b_mag  = bus.b_in;
  assign w_result = r_acc;
`endif

  assign w_eqz = (r_b == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_eqz) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_product <= '0;
`ifdef MULT_SIGNED_EN
      r_neg     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a   <= {{WIDTH{1'b0}}, w_a_mag};
            r_b   <= w_b_mag;
            r_acc <= '0;
`ifdef MULT_SIGNED_EN
            r_neg <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          // Decrement only while nonzero so the counter never wraps.
          if (w_eqz) begin
            r_product <= w_result;
          end else begin
            r_acc <= r_acc + r_a;
            r_b   <= r_b - WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.product = r_product;
endmodule
